// File: rtl/frame_swap_ctrl_pkg.sv
// Shared definitions for the camera/display ping-pong frame buffer controller.
// FSM state encoding, default frame geometry and the bank-index width.
package frame_swap_ctrl_pkg;

  // Controller states: waiting for a frame, writing a frame, holding a full frame
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  // 80x60 frame, 4:4:4 pixel word
  localparam int C_IMG_PXLS    = 4800;
  localparam int C_NB_IMG_PXLS = 13;
  localparam int C_NB_BUF      = 12;

  // Two banks, so a single bit selects one of them
  localparam int C_NB_BANK     = 1;

endpackage

// File: rtl/frame_swap_ctrl_sync_edge_det.sv
// Single-register edge detector for a level that is already synchronous to clk.
// Reports rising, falling and "entered the active level" edges by comparing the
// current input against its value one cycle earlier. The history register resets
// to c_rst_val (the inactive level) so no edge is reported on reset release.
module sync_edge_det #(
  parameter logic c_rst_val = 1'b0,
  parameter logic c_act     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall,
  output logic act_edge
);

  logic sig_q;

  // Remember the previous sample of the input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= c_rst_val;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise     = sig & ~sig_q;
  assign fall     = ~sig & sig_q;
  assign act_edge = (sig == c_act) && (sig_q != c_act);

endmodule

// File: rtl/frame_swap_ctrl.sv
// Ping-pong frame buffer controller.
// Camera pixels are written into the back bank; the display reads the front bank.
// Banks swap on a display vsync edge, and only after a full camera frame has been
// written, so the display never shows a torn frame.
//
// Valid/ready semantics: the camera side has no backpressure. A pixel is taken on
// every cycle cam_pxl_valid is high while capturing, and appears on the write port
// (wr_en/wr_addr/wr_data/wr_bank) exactly one cycle later. Pixels offered outside
// a capture are dropped silently.
//
// Optional build macro FRAME_DROP_CNT_EN adds a saturating drop_cnt output that
// counts camera frames lost while a full frame waits for the swap, plus short
// frames aborted by an early camera vsync.
module frame_swap_ctrl
  import frame_swap_ctrl_pkg::*;
#(
  parameter logic c_synch_act   = 1'b0,
  parameter int   c_img_pxls    = C_IMG_PXLS,
  parameter int   c_nb_img_pxls = C_NB_IMG_PXLS,
  parameter int   c_nb_buf      = C_NB_BUF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_vsync,
  input  logic                     cam_pxl_valid,
  input  logic [c_nb_buf-1:0]      cam_pxl,
  input  logic                     disp_vsync,
  output logic                     wr_en,
  output logic [C_NB_BANK-1:0]     wr_bank,
  output logic [c_nb_img_pxls-1:0] wr_addr,
  output logic [c_nb_buf-1:0]      wr_data,
  output logic [C_NB_BANK-1:0]     rd_bank,
  output logic                     frame_done,
  output logic [1:0]               dbg_state
`ifdef FRAME_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  state_t                   state;
  logic [c_nb_img_pxls-1:0] pxl_cnt;

  logic cam_rise;
  logic cam_fall;
  logic cam_act_edge;
  logic disp_rise;
  logic disp_fall;
  logic disp_edge;
  logic unused_edges;

  logic in_range;
  logic last_pxl;
  logic pxl_take;

  // Camera vsync: idle level is high, so its history resets high
  sync_edge_det #(
    .c_rst_val (1'b1),
    .c_act     (1'b0)
  ) u_cam_edge (
    .clk      (clk),
    .rst      (rst),
    .sig      (cam_vsync),
    .rise     (cam_rise),
    .fall     (cam_fall),
    .act_edge (cam_act_edge)
  );

  // Display vsync: history resets to the inactive level
  sync_edge_det #(
    .c_rst_val (~c_synch_act),
    .c_act     (c_synch_act)
  ) u_disp_edge (
    .clk      (clk),
    .rst      (rst),
    .sig      (disp_vsync),
    .rise     (disp_rise),
    .fall     (disp_fall),
    .act_edge (disp_edge)
  );

  assign unused_edges = cam_act_edge ^ disp_rise ^ disp_fall;

  // The count never reaches c_img_pxls, but the guard keeps wr_en off any
  // out-of-frame address regardless of how the counter got there.
  assign in_range = (pxl_cnt < c_nb_img_pxls'(c_img_pxls));
  assign last_pxl = (pxl_cnt == c_nb_img_pxls'(c_img_pxls - 1));
  assign pxl_take = (state == CAPTURE) && cam_pxl_valid && in_range;

  // Frame sequencing FSM with registered write port and bank selects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pxl_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_bank    <= 1'b0;
      wr_bank    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cam_fall) begin
            state   <= CAPTURE;
            pxl_cnt <= '0;
            wr_addr <= '0;
          end
        end
        CAPTURE: begin
          if (pxl_take) begin
            wr_en   <= 1'b1;
            wr_data <= cam_pxl;
            wr_addr <= pxl_cnt;
            if (last_pxl) begin
              // Completion wins over a simultaneous camera vsync rise
              pxl_cnt <= '0;
              state   <= READY;
            end else begin
              pxl_cnt <= pxl_cnt + 1'b1;
              if (cam_rise) begin
                state <= IDLE;
              end
            end
          end else if (cam_rise) begin
            // Short frame: abandon it, front bank untouched
            state <= IDLE;
          end
        end
        READY: begin
          // Camera frames arriving here are dropped; only the display edge matters
          if (disp_edge) begin
            rd_bank    <= ~rd_bank;
            wr_bank    <= rd_bank;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

`ifdef FRAME_DROP_CNT_EN
  logic drop_evt;

  assign drop_evt = ((state == READY) && cam_fall) ||
                    ((state == CAPTURE) && cam_rise && !(pxl_take && last_pxl));

  // Saturating count of lost camera frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (drop_evt && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  // Without the drop counter, lost frames are simply not recorded.
`endif

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Bench for frame_swap_ctrl: directed camera frames and display vsync pulses.
// Writes and swaps are predicted into queues at stimulus time and checked by a
// monitor on the falling clock edge. A second instance with an active-high
// display vsync covers the polarity parameter.
module tb_frame_swap_ctrl;

  localparam int W = 26;  // {wr_bank, wr_addr[12:0], wr_data[11:0]}

  logic        clk;
  logic        rst;
  logic        cam_vsync;
  logic        cam_pxl_valid;
  logic [11:0] cam_pxl;
  logic        disp_vsync;
  logic        disp_vsync_h;

  logic        wr_en, wr_bank, rd_bank, frame_done;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic [1:0]  dbg_state;

  logic        wr_en_h, wr_bank_h, rd_bank_h, frame_done_h;
  logic [12:0] wr_addr_h;
  logic [11:0] wr_data_h;
  logic [1:0]  dbg_state_h;
`ifdef FRAME_DROP_CNT_EN
  logic [7:0]  drop_cnt;
  logic [7:0]  drop_cnt_h;
`endif

  logic [W-1:0] exp_q[$];
  logic [1:0]   swap_q[$];   // expected {rd_bank, wr_bank} after each swap
  int           n_vec;
  int           n_err;
  int           fd_h_cnt;

  frame_swap_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cam_vsync     (cam_vsync),
    .cam_pxl_valid (cam_pxl_valid),
    .cam_pxl       (cam_pxl),
    .disp_vsync    (disp_vsync),
    .wr_en         (wr_en),
    .wr_bank       (wr_bank),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_bank       (rd_bank),
    .frame_done    (frame_done),
    .dbg_state     (dbg_state)
`ifdef FRAME_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  frame_swap_ctrl #(.c_synch_act(1'b1)) dut_h (
    .clk           (clk),
    .rst           (rst),
    .cam_vsync     (cam_vsync),
    .cam_pxl_valid (cam_pxl_valid),
    .cam_pxl       (cam_pxl),
    .disp_vsync    (disp_vsync_h),
    .wr_en         (wr_en_h),
    .wr_bank       (wr_bank_h),
    .wr_addr       (wr_addr_h),
    .wr_data       (wr_data_h),
    .rd_bank       (rd_bank_h),
    .frame_done    (frame_done_h),
    .dbg_state     (dbg_state_h)
`ifdef FRAME_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt_h)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write and every swap must match the head of its queue
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    logic [1:0]   sw;
    if (wr_en) begin
      n_vec++;
      got = {wr_bank, wr_addr, wr_data};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got bank=%0d addr=%0d data=%03h, required no write",
                 wr_bank, wr_addr, wr_data);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL write: got bank=%0d addr=%0d data=%03h, required bank=%0d addr=%0d data=%03h",
                   got[25], got[24:12], got[11:0], exp[25], exp[24:12], exp[11:0]);
        end
      end
    end
    if (frame_done) begin
      n_vec++;
      if (swap_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_swap: got frame_done rd_bank=%0d, required no swap", rd_bank);
      end else begin
        sw = swap_q.pop_front();
        if ({rd_bank, wr_bank} !== sw) begin
          n_err++;
          $display("FAIL swap_banks: got rd=%0d wr=%0d, required rd=%0d wr=%0d",
                   rd_bank, wr_bank, sw[1], sw[0]);
        end
      end
    end
    if (frame_done_h) fd_h_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One camera frame: vsync low, n back-to-back pixels, vsync high.
  // mode 1: display vsync goes active on the last pixel; mode 2: camera vsync rises on it.
  task automatic cam_frame(input int n, input bit exp_wr, input logic bank,
                           input int seed, input int mode);
    logic [11:0] d;
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      d = 12'((i * 37 + seed) & 32'hFFF);
      cam_pxl       = d;
      cam_pxl_valid = 1'b1;
      if (i == n - 1 && mode == 1) disp_vsync = 1'b0;
      if (i == n - 1 && mode == 2) cam_vsync = 1'b1;
      if (exp_wr) exp_q.push_back({bank, 13'(i), d});
      @(negedge clk);
    end
    cam_pxl_valid = 1'b0;
    cam_pxl       = '0;
    @(negedge clk);
    cam_vsync = 1'b1;
    @(negedge clk);
  endtask

  // Active-low display vsync pulse for the default instance
  task automatic disp_pulse();
    disp_vsync = 1'b0;
    repeat (3) @(negedge clk);
    disp_vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [11:0] d;
    n_vec = 0;
    n_err = 0;
    fd_h_cnt = 0;
    rst = 1'b1;
    cam_vsync = 1'b1;
    cam_pxl_valid = 1'b0;
    cam_pxl = '0;
    disp_vsync = 1'b1;
    disp_vsync_h = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_wr_bank", wr_bank, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_state", dbg_state, 0);

    // Full frame into bank 1, then three display edges: only the first swaps
    cam_frame(4800, 1'b1, 1'b1, 5, 0);
    check("full_state_ready", dbg_state, 2);
    check("full_rd_before", rd_bank, 0);
    swap_q.push_back(2'b10);
    disp_pulse();
    check("full_rd_after", rd_bank, 1);
    check("full_wr_after", wr_bank, 0);
    disp_pulse();
    disp_pulse();
    check("full_no_reswap", rd_bank, 1);

    // Short frame: 100 pixels, camera vsync rises with the last one
    cam_frame(100, 1'b1, 1'b0, 11, 2);
    check("short_state_idle", dbg_state, 0);
    check("short_rd_bank", rd_bank, 1);
`ifdef FRAME_DROP_CNT_EN
    check("short_drop_cnt", drop_cnt, 1);
`endif
    disp_pulse();
    check("short_no_swap", rd_bank, 1);

    // Frame completes in the same cycle as a display edge: swap only on the next one
    cam_frame(4800, 1'b1, 1'b0, 23, 1);
    check("coinc_state_ready", dbg_state, 2);
    check("coinc_rd_held", rd_bank, 1);
    disp_vsync = 1'b1;
    repeat (2) @(negedge clk);
    check("coinc_rd_still", rd_bank, 1);
    swap_q.push_back(2'b01);
    disp_pulse();
    check("coinc_rd_swapped", rd_bank, 0);
    check("coinc_state_idle", dbg_state, 0);

    // Second camera frame while READY is dropped; the swap still follows
    cam_frame(4800, 1'b1, 1'b1, 41, 0);
    check("drop_state_ready", dbg_state, 2);
    cam_frame(50, 1'b0, 1'b0, 3, 0);
    check("drop_state_still", dbg_state, 2);
`ifdef FRAME_DROP_CNT_EN
    check("drop_cnt_ready", drop_cnt, 2);
`endif
    swap_q.push_back(2'b10);
    disp_pulse();
    check("drop_rd_swapped", rd_bank, 1);

    // Reset while wr_addr is 2000
    cam_vsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i <= 2000; i++) begin
      d = 12'((i * 37 + 7) & 32'hFFF);
      cam_pxl       = d;
      cam_pxl_valid = 1'b1;
      exp_q.push_back({1'b0, 13'(i), d});
      @(negedge clk);
    end
    cam_pxl_valid = 1'b0;
    cam_vsync = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_rd_bank", rd_bank, 0);
    check("mid_rst_wr_bank", wr_bank, 1);
    check("mid_rst_state", dbg_state, 0);
`ifdef FRAME_DROP_CNT_EN
    check("mid_rst_drop_cnt", drop_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cam_frame(10, 1'b1, 1'b1, 99, 2);
    check("after_rst_state", dbg_state, 0);
`ifdef FRAME_DROP_CNT_EN
    check("after_rst_drop_cnt", drop_cnt, 1);
`endif

    // Active-high display vsync instance: rising edge swaps, falling edge does not
    disp_vsync_h = 1'b1;
    repeat (2) @(negedge clk);
    cam_frame(4800, 1'b1, 1'b1, 17, 0);
    check("pol_state_ready", dbg_state_h, 2);
    disp_vsync_h = 1'b0;
    repeat (3) @(negedge clk);
    check("pol_fall_rd", rd_bank_h, 0);
    check("pol_fall_done", fd_h_cnt, 0);
    disp_vsync_h = 1'b1;
    repeat (3) @(negedge clk);
    check("pol_rise_rd", rd_bank_h, 1);
    check("pol_rise_wr", wr_bank_h, 0);
    check("pol_rise_done", fd_h_cnt, 1);
    check("pol_rise_state", dbg_state_h, 0);
    check("pol_main_rd", rd_bank, 0);

    repeat (3) @(negedge clk);
    check("writes_left", exp_q.size(), 0);
    check("swaps_left", swap_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
